// File: rtl/wallace_mac_pkg.sv
// wallace_mac_pkg: shared sizing constants, FSM states and the carry-save helper
// used by the Wallace multiplier tree.
package wallace_mac_pkg;
    localparam int MAX_TERMS = 16;
    localparam int ACC_W = 20;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] c;
    } csa_t;

    // 3:2 compressor over whole rows; carries out of bit 15 are dropped since
    // an 8x8 product never exceeds 16 bits.
    function automatic csa_t csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        return '{s: x ^ y ^ z, c: ((x & y) | (x & z) | (y & z)) << 1};
    endfunction
endpackage

// File: rtl/problem5.sv
// problem5: unsigned 8x8 Wallace-tree multiplier, reducing eight partial
// product rows 8->6->4->3->2 with carry-save adders and one final add.
module problem5
    import wallace_mac_pkg::*;
(
    input  logic [7:0]  IN1,
    input  logic [7:0]  IN2,
    output logic [15:0] OUT
);
    logic [15:0] pp [8];
    csa_t l1a, l1b, l2a, l2b, l3, l4;

    for (genvar i = 0; i < 8; i++) begin : g_pp
        assign pp[i] = 16'(IN1 & {8{IN2[i]}}) << i;
    end

    assign l1a = csa(pp[0], pp[1], pp[2]);
    assign l1b = csa(pp[3], pp[4], pp[5]);
    assign l2a = csa(l1a.s, l1a.c, l1b.s);
    assign l2b = csa(l1b.c, pp[6], pp[7]);
    assign l3  = csa(l2a.s, l2a.c, l2b.s);
    assign l4  = csa(l3.s, l3.c, l2b.c);
    assign OUT = l4.s + l4.c;
endmodule

// File: rtl/wallace_mac.sv
// wallace_mac: streaming multiply-accumulate; operand reg -> Wallace product reg
// -> accumulator, with an ACCUM/DRAIN/DONE handshake around each finished sum.
module wallace_mac #(
    parameter int MAX_TERMS = wallace_mac_pkg::MAX_TERMS,
    parameter int ACC_W = wallace_mac_pkg::ACC_W,
    parameter int CNT_W = wallace_mac_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [7:0]       IN1,
    input  logic [7:0]       IN2,
    input  logic             LAST,
    input  logic             CLEAR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] OUT,
    output logic [CNT_W-1:0] COUNT
);
    import wallace_mac_pkg::*;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

    state_t state, nstate;
    logic [7:0] a_r, b_r;
    logic [15:0] prod, p_r;
    logic v1, v2, last1, last2;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic accept, term_last, clr, done_hs, fin;

    assign IN_READY  = (state == ACCUM) && !CLEAR;
    assign accept    = IN_VALID && IN_READY;
    assign term_last = LAST || (cnt == LAST_CNT);
    assign clr       = CLEAR && (state == ACCUM);
    assign done_hs   = (state == DONE) && OUT_READY;
    assign fin       = v2 && last2;
    assign OUT_VALID = (state == DONE);
    assign OUT       = acc;
    assign COUNT     = cnt;

    problem5 u_mul (.IN1(a_r), .IN2(b_r), .OUT(prod));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ACCUM;
        else state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (state == ACCUM && accept && term_last) nstate = DRAIN;
        else if (state == DRAIN && fin) nstate = DONE;
        else if (done_hs) nstate = ACCUM;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_r   <= '0;
            b_r   <= '0;
            p_r   <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            last1 <= 1'b0;
            last2 <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            v1    <= accept;
            last1 <= term_last;
            if (accept) begin
                a_r <= IN1;
                b_r <= IN2;
            end
            // an abort kills the beat moving into the product stage as well
            v2    <= v1 && !clr;
            last2 <= last1;
            p_r   <= prod;
            if (clr || done_hs) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                if (v2) acc <= acc + ACC_W'(p_r);
                if (accept && cnt != FULL_CNT) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wallace_mac.sv
// tb_wallace_mac: directed vector table of whole sums plus hand-written
// backpressure, abort and mid-sum reset sequences.
module tb_wallace_mac;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [7:0]  IN1 = '0;
    logic [7:0]  IN2 = '0;
    logic        LAST = 1'b0;
    logic        CLEAR = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [19:0] OUT;
    logic [4:0]  COUNT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         n;
        logic [7:0] a;
        logic [7:0] b;
        logic       lst;
        int         exp_out;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [8];

    wallace_mac dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN1(IN1), .IN2(IN2), .LAST(LAST), .CLEAR(CLEAR),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_beats(input int n, input logic [7:0] a, input logic [7:0] b, input logic lst);
        for (int i = 0; i < n; i++) begin
            IN_VALID = 1'b1;
            IN1 = a;
            IN2 = b;
            LAST = lst && (i == n - 1);
            tick();
        end
        IN_VALID = 1'b0;
        LAST = 1'b0;
    endtask

    task automatic wait_result(input string nm, input int exp_out, input int exp_cnt);
        int cyc;
        cyc = 0;
        chk({nm, " ready_drain"}, int'(IN_READY), 0);
        while (!OUT_VALID && cyc < 10) begin
            tick();
            cyc++;
        end
        chk({nm, " latency"}, cyc, 2);
        chk({nm, " out"}, int'(OUT), exp_out);
        chk({nm, " count"}, int'(COUNT), exp_cnt);
    endtask

    task automatic handshake(input string nm);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk({nm, " valid_drop"}, int'(OUT_VALID), 0);
        chk({nm, " ready_back"}, int'(IN_READY), 1);
        chk({nm, " count_clr"}, int'(COUNT), 0);
        chk({nm, " out_clr"}, int'(OUT), 0);
    endtask

    initial begin
        vecs[0] = '{1, 8'd43, 8'd112, 1'b1, 4816, 1};
        vecs[1] = '{4, 8'd255, 8'd255, 1'b1, 260100, 4};
        vecs[2] = '{16, 8'd255, 8'd255, 1'b0, 1040400, 16};
        vecs[3] = '{3, 8'd7, 8'd9, 1'b1, 189, 3};
        vecs[4] = '{2, 8'd0, 8'd200, 1'b1, 0, 2};
        vecs[5] = '{5, 8'd1, 8'd255, 1'b1, 1275, 5};
        vecs[6] = '{1, 8'd255, 8'd1, 1'b1, 255, 1};
        vecs[7] = '{1, 8'd128, 8'd2, 1'b1, 256, 1};

        #2;
        chk("rst out", int'(OUT), 0);
        chk("rst count", int'(COUNT), 0);
        chk("rst valid", int'(OUT_VALID), 0);
        tick();
        RESET = 1'b0;
        tick();
        chk("rst ready", int'(IN_READY), 1);

        for (int v = 0; v < 8; v++) begin
            drive_beats(vecs[v].n, vecs[v].a, vecs[v].b, vecs[v].lst);
            wait_result($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_cnt);
            handshake($sformatf("vec%0d", v));
        end

        // backpressure: result must hold while IN_VALID and CLEAR are ignored
        drive_beats(1, 8'd3, 8'd5, 1'b1);
        wait_result("bp", 15, 1);
        IN_VALID = 1'b1;
        CLEAR = 1'b1;
        IN1 = 8'd9;
        IN2 = 8'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d out", i), int'(OUT), 15);
            chk($sformatf("bp%0d count", i), int'(COUNT), 1);
            chk($sformatf("bp%0d ready", i), int'(IN_READY), 0);
            chk($sformatf("bp%0d valid", i), int'(OUT_VALID), 1);
        end
        IN_VALID = 1'b0;
        CLEAR = 1'b0;
        handshake("bp");

        // abort after two beats; CLEAR beats a simultaneous IN_VALID
        drive_beats(1, 8'd10, 8'd10, 1'b0);
        drive_beats(1, 8'd20, 8'd20, 1'b0);
        chk("clr pre count", int'(COUNT), 2);
        CLEAR = 1'b1;
        IN_VALID = 1'b1;
        IN1 = 8'd99;
        IN2 = 8'd99;
        #1;
        chk("clr ready", int'(IN_READY), 0);
        tick();
        CLEAR = 1'b0;
        IN_VALID = 1'b0;
        chk("clr count", int'(COUNT), 0);
        tick();
        chk("clr out", int'(OUT), 0);
        drive_beats(1, 8'd3, 8'd4, 1'b1);
        wait_result("clr", 12, 1);
        handshake("clr");

        // asynchronous reset in the middle of a five-beat sum
        drive_beats(3, 8'd6, 8'd7, 1'b0);
        chk("mid out", int'(OUT), 42);
        IN_VALID = 1'b1;
        #1;
        RESET = 1'b1;
        IN_VALID = 1'b0;
        #1;
        chk("arst out", int'(OUT), 0);
        chk("arst count", int'(COUNT), 0);
        chk("arst valid", int'(OUT_VALID), 0);
        #1;
        RESET = 1'b0;
        tick();
        chk("arst ready", int'(IN_READY), 1);
        tick();
        chk("arst flush", int'(OUT), 0);
        drive_beats(1, 8'd1, 8'd1, 1'b1);
        wait_result("arst", 1, 1);
        handshake("arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
